add_8_bit: RTL and testbench



---
 rtl/add_8_bit_if.sv | 21 ++
 rtl/add_8_bit.sv | 64 ++++++
 tb/tb_add_8_bit.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/add_8_bit_if.sv
// Operand/result bundle for the registered 8-bit adder.
// The Overflow/Zero flags exist only when ADD8_FLAGS_EN is defined.
interface add_8_bit_if;
    logic [7:0] A;
    logic [7:0] B;
    logic       cin;
    logic [7:0] Sum;
    logic       CarryOut;
`ifdef ADD8_FLAGS_EN
    logic       Overflow;
    logic       Zero;
`endif

`ifdef ADD8_FLAGS_EN
    modport master (output A, B, cin, input Sum, CarryOut, Overflow, Zero);
    modport slave  (input A, B, cin, output Sum, CarryOut, Overflow, Zero);
`else
    modport master (output A, B, cin, input Sum, CarryOut);
    modport slave  (input A, B, cin, output Sum, CarryOut);
`endif
endinterface

// File: rtl/add_8_bit.sv
// Ripple-carry 8-bit adder with carry-in and a one-cycle registered result.
// Define ADD8_FLAGS_EN to add registered signed-overflow and zero flags.
module add_8_bit (
    input  logic          clk,
    input  logic          rst,
    add_8_bit_if.slave    bus
);

    logic [8:0] carry;
    logic [7:0] sumBits;

    logic [7:0] sum_d, sum_q;
    logic       carry_d, carry_q;

    // Explicit full-adder chain: carry[i] is the carry into bit i.
    always_comb begin
        carry    = '0;
        sumBits  = '0;
        carry[0] = bus.cin;
        for (int i = 0; i < 8; i++) begin
            sumBits[i]   = bus.A[i] ^ bus.B[i] ^ carry[i];
            carry[i+1]   = (bus.A[i] & bus.B[i]) | (carry[i] & (bus.A[i] ^ bus.B[i]));
        end
    end

    assign sum_d   = sumBits;
    assign carry_d = carry[8];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q   <= 8'h00;
            carry_q <= 1'b0;
        end else begin
            sum_q   <= sum_d;
            carry_q <= carry_d;
        end
    end

    assign bus.Sum      = sum_q;
    assign bus.CarryOut = carry_q;

`ifdef ADD8_FLAGS_EN
    logic overflow_d, overflow_q;
    logic zero_d, zero_q;

    // Signed overflow is exactly a disagreement between the carries into and out of bit 7.
    assign overflow_d = carry[7] ^ carry[8];
    assign zero_d     = (sumBits == 8'h00);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_q <= 1'b0;
            zero_q     <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
            zero_q     <= zero_d;
        end
    end

    assign bus.Overflow = overflow_q;
    assign bus.Zero     = zero_q;
`endif

endmodule

// File: tb/tb_add_8_bit.sv
// Self-checking bench for add_8_bit: directed literal vectors plus random
// back-to-back traffic compared every cycle against an arithmetic model.
module tb_add_8_bit;

    logic clk;
    logic rst;
    add_8_bit_if bus ();

    add_8_bit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int numCompared   = 0;
    int numMismatched = 0;
    bit checkEn       = 1'b0;

    // Reference: registered result of plain integer arithmetic on last sampled inputs.
    logic [8:0] modelResult   = 9'd0;
    logic       modelOverflow = 1'b0;
    logic       modelZero     = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or posedge rst) begin
        int signedResult;
        if (rst) begin
            modelResult   = 9'd0;
            modelOverflow = 1'b0;
            modelZero     = 1'b0;
        end else begin
            modelResult   = {1'b0, bus.A} + {1'b0, bus.B} + {8'd0, bus.cin};
            signedResult  = int'($signed(bus.A)) + int'($signed(bus.B)) + int'(bus.cin);
            modelOverflow = (signedResult > 127) || (signedResult < -128);
            modelZero     = (modelResult[7:0] == 8'h00);
        end
    end

    // Per-cycle comparison against the model, sampled mid-cycle.
    always @(negedge clk) begin
        if (checkEn) begin
            numCompared++;
            if ({bus.CarryOut, bus.Sum} !== modelResult) begin
                numMismatched++;
                $display("[TB] FAIL model_sum at %0t: got %h, expected %h", $time,
                         {bus.CarryOut, bus.Sum}, modelResult);
            end
`ifdef ADD8_FLAGS_EN
            numCompared++;
            if ({bus.Overflow, bus.Zero} !== {modelOverflow, modelZero}) begin
                numMismatched++;
                $display("[TB] FAIL model_flags at %0t: got ovf/zero %b%b, expected %b%b",
                         $time, bus.Overflow, bus.Zero, modelOverflow, modelZero);
            end
`endif
        end
    end

    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic c);
        bus.A   = a;
        bus.B   = b;
        bus.cin = c;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [7:0] expSum, input logic expCarry);
        numCompared++;
        if (bus.Sum !== expSum || bus.CarryOut !== expCarry) begin
            numMismatched++;
            $display("[TB] FAIL %s: got Sum=%h CarryOut=%b, expected Sum=%h CarryOut=%b",
                     name, bus.Sum, bus.CarryOut, expSum, expCarry);
        end
    endtask

`ifdef ADD8_FLAGS_EN
    task automatic checkFlags(input string name, input logic expOvf, input logic expZero);
        numCompared++;
        if (bus.Overflow !== expOvf || bus.Zero !== expZero) begin
            numMismatched++;
            $display("[TB] FAIL %s: got Overflow=%b Zero=%b, expected Overflow=%b Zero=%b",
                     name, bus.Overflow, bus.Zero, expOvf, expZero);
        end
    endtask
`endif

    initial begin
        rst     = 1'b1;
        bus.A   = 8'hAA;
        bus.B   = 8'h55;
        bus.cin = 1'b0;
        #2;
        checkOutput("reset_async", 8'h00, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("reset_held_edge", 8'h00, 1'b0);
`ifdef ADD8_FLAGS_EN
        checkFlags("reset_flags", 1'b0, 1'b0);
`endif
        rst     = 1'b0;
        checkEn = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("first_after_reset", 8'hFF, 1'b0);

        applyStimulus(8'h01, 8'h01, 1'b0);
        checkOutput("one_plus_one", 8'h02, 1'b0);
        applyStimulus(8'hFF, 8'h01, 1'b0);
        checkOutput("wrap_ff_01", 8'h00, 1'b1);
`ifdef ADD8_FLAGS_EN
        checkFlags("wrap_ff_01_flags", 1'b0, 1'b1);
`endif
        applyStimulus(8'hAA, 8'h55, 1'b0);
        checkOutput("aa_55", 8'hFF, 1'b0);
        applyStimulus(8'hF0, 8'h0F, 1'b0);
        checkOutput("f0_0f", 8'hFF, 1'b0);
        applyStimulus(8'hFF, 8'hFF, 1'b1);
        checkOutput("max_case", 8'hFF, 1'b1);
        applyStimulus(8'h7F, 8'h01, 1'b0);
        checkOutput("7f_01", 8'h80, 1'b0);
`ifdef ADD8_FLAGS_EN
        checkFlags("7f_01_flags", 1'b1, 1'b0);
`endif
        applyStimulus(8'h00, 8'h00, 1'b1);
        checkOutput("cin_only", 8'h01, 1'b0);
        applyStimulus(8'h80, 8'h80, 1'b0);
        checkOutput("80_80", 8'h00, 1'b1);

        // Random back-to-back traffic with a mid-cycle reset pulse.
        for (int i = 0; i < 300; i++) begin
            if (i == 150) begin
                bus.A   = 8'($urandom);
                bus.B   = 8'($urandom);
                bus.cin = 1'($urandom);
                #2;
                rst = 1'b1;
                #1;
                checkOutput("reset_midstream", 8'h00, 1'b0);
                @(posedge clk);
                #1;
                checkOutput("reset_mid_edge", 8'h00, 1'b0);
                rst = 1'b0;
            end
            applyStimulus(8'($urandom), 8'($urandom), 1'($urandom));
        end

        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
        $finish;
    end

endmodule
